conv_tile_scheduler: RTL

//  Sequences the 3x3xD, 16-filter convolution datapath over a SIDE x SIDE feature map.
//  Per output pixel: request a window, restart the conv unit, wait for completion, capture the result vector.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_tile_scheduler_raster.sv | 58 +++++
 rtl/conv_tile_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv tile datapath: scheduler state codes and
// default geometry/timing constants used by the scheduler, conv unit and fetcher.
package conv_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_LAUNCH = 3'd2;
    localparam state_t S_WAIT   = 3'd3;
    localparam state_t S_EMIT   = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    localparam int unsigned SIDE_DEF = 256;
    localparam int unsigned D_DEF    = 3;
    localparam int unsigned F_DEF    = 3;
    localparam int unsigned CW       = $clog2(SIDE_DEF);
    localparam int unsigned ACC_WAIT = D_DEF * F_DEF * F_DEF + 1;

    // Cycles during which conv_idle is still stale after a conv unit restart
    function automatic int unsigned acc_wait_cycles(input int unsigned d, input int unsigned f);
        return d * f * f + 1;
    endfunction

endpackage

// File: rtl/conv_tile_scheduler_raster.sv
// Row/column raster position over a SIDE x SIDE map, wrapping to (0,0)
// after the last pixel, with a last-pixel flag.
module raster_counter
    import conv_pkg::*;
#(
    parameter int unsigned SIDE = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    advance_i,
    output logic [$clog2(SIDE)-1:0] row_o,
    output logic [$clog2(SIDE)-1:0] col_o,
    output logic                    last_o
);

    localparam int unsigned RCW = $clog2(SIDE);
    localparam logic [RCW-1:0] LAST = RCW'(SIDE - 1);

    logic [RCW-1:0] row_q, row_d;
    logic [RCW-1:0] col_q, col_d;
    logic           row_last;
    logic           col_last;

    assign row_last = (row_q == LAST);
    assign col_last = (col_q == LAST);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = row_last && col_last;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Per-pixel sequencer for the 3x3xD conv datapath: fetch window, restart conv
// unit, wait for completion (with timeout), hand the result vector downstream.
module conv_tile_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SIDE       = 256,
    parameter int unsigned D          = 3,
    parameter int unsigned F          = 3,
    parameter int unsigned FILTER_NUM = 16,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             win_req,
    input  logic                             win_ack,
    output logic [$clog2(SIDE)-1:0]          win_row,
    output logic [$clog2(SIDE)-1:0]          win_col,
    output logic                             conv_rst,
    input  logic                             conv_idle,
    input  logic [FILTER_NUM*DATA_WIDTH-1:0] conv_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [FILTER_NUM*DATA_WIDTH-1:0] out_data,
    output logic [$clog2(SIDE)-1:0]          out_row,
    output logic [$clog2(SIDE)-1:0]          out_col
);

    localparam int unsigned RCW = $clog2(SIDE);
    localparam int unsigned RW  = FILTER_NUM * DATA_WIDTH;
    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
    localparam int unsigned LCW = $clog2(RST_CYCLES + 1);

    localparam logic [WCW-1:0] ACC_LIM     = WCW'(acc_wait_cycles(D, F));
    localparam logic [WCW-1:0] TO_LIM      = WCW'(TIMEOUT);
    localparam logic [LCW-1:0] LAUNCH_LAST = LCW'(RST_CYCLES - 1);

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            win_req_q, win_req_d;
    logic            conv_rst_q, conv_rst_d;
    logic            out_valid_q, out_valid_d;
    logic [RW-1:0]   out_data_q, out_data_d;
    logic [RCW-1:0]  out_row_q, out_row_d;
    logic [RCW-1:0]  out_col_q, out_col_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [LCW-1:0]  rst_cnt_q, rst_cnt_d;

    logic            ctr_clear;
    logic            ctr_advance;
    logic            ctr_last;

    raster_counter #(
        .SIDE (SIDE)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (ctr_clear),
        .advance_i (ctr_advance),
        .row_o     (win_row),
        .col_o     (win_col),
        .last_o    (ctr_last)
    );

    // All outputs are registered, so each transition sets the next state's output values
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        win_req_d   = win_req_q;
        conv_rst_d  = conv_rst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        wait_cnt_d  = wait_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        ctr_clear   = 1'b0;
        ctr_advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                conv_rst_d = 1'b1;
                if (start) begin
                    ctr_clear  = 1'b1;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    win_req_d  = 1'b1;
                    conv_rst_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (win_ack) begin
                    win_req_d  = 1'b0;
                    conv_rst_d = 1'b1;
                    rst_cnt_d  = '0;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (rst_cnt_q == LAUNCH_LAST) begin
                    conv_rst_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // conv_idle is untrustworthy until the MAC sequence has had time to run
                if (wait_cnt_q >= ACC_LIM && conv_idle) begin
                    out_data_d  = conv_result;
                    out_row_d   = win_row;
                    out_col_d   = win_col;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (wait_cnt_q == TO_LIM) begin
                    err_d       = 1'b1;
                    out_data_d  = '0;
                    out_row_d   = win_row;
                    out_col_d   = win_col;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ctr_advance = 1'b1;
                    if (ctr_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        win_req_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                conv_rst_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                busy_d      = 1'b0;
                win_req_d   = 1'b0;
                out_valid_d = 1'b0;
                conv_rst_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            win_req_q   <= 1'b0;
            conv_rst_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            wait_cnt_q  <= '0;
            rst_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            win_req_q   <= win_req_d;
            conv_rst_q  <= conv_rst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            wait_cnt_q  <= wait_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign win_req   = win_req_q;
    assign conv_rst  = conv_rst_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule
